// File: rtl/gate_exerciser_if.sv
// Bundle of control/status and gate-under-test signals for gate_exerciser.
// The exerciser uses the slave view; the board top or a bench uses the master view.
interface gate_exerciser_if;
  logic       start;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;

  modport slave (
    input  start,
    input  y_in,
    output a_out,
    output b_out,
    output busy,
    output done,
    output pass,
    output fail_vec
  );

  modport master (
    output start,
    output y_in,
    input  a_out,
    input  b_out,
    input  busy,
    input  done,
    input  pass,
    input  fail_vec
  );
endinterface

// File: rtl/gate_exerciser.sv
// Walks a two-input gate through all four {a,b} vectors, waits a settle time,
// samples the synchronized Y and reports a pass flag plus per-vector failure map.
module gate_exerciser #(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [3:0] TRUTH         = 4'b1000
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_exerciser_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_nx;
  logic [1:0] idx, idx_nx, idx_inc;
  logic [7:0] cnt, cnt_nx;
  logic       a_r, a_nx;
  logic       b_r, b_nx;
  logic       busy_r, busy_nx;
  logic       pass_r, pass_nx;
  logic [3:0] fail_r, fail_nx, fail_cur;
  logic       done_c;
  logic       mismatch;
  logic       y_meta, y_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= 2'd0;
      cnt    <= 8'd0;
      a_r    <= 1'b0;
      b_r    <= 1'b0;
      busy_r <= 1'b0;
      pass_r <= 1'b0;
      fail_r <= 4'd0;
      y_meta <= 1'b0;
      y_sync <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      cnt    <= cnt_nx;
      a_r    <= a_nx;
      b_r    <= b_nx;
      busy_r <= busy_nx;
      pass_r <= pass_nx;
      fail_r <= fail_nx;
      y_meta <= bus.y_in;
      y_sync <= y_meta;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    a_nx     = a_r;
    b_nx     = b_r;
    busy_nx  = busy_r;
    pass_nx  = pass_r;
    fail_nx  = fail_r;
    done_c   = 1'b0;
    idx_inc  = idx + 2'd1;
    mismatch = (y_sync != TRUTH[idx]);
    // Failure map including the comparison being made this cycle, so the
    // final pass decision sees the last vector too.
    fail_cur      = fail_r;
    fail_cur[idx] = mismatch;

    case (state)
      IDLE: begin
        if (bus.start) begin
          idx_nx   = 2'd0;
          cnt_nx   = 8'd0;
          fail_nx  = 4'd0;
          pass_nx  = 1'b0;
          busy_nx  = 1'b1;
          a_nx     = 1'b0;
          b_nx     = 1'b0;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        cnt_nx = cnt + 8'd1;
        if (cnt == CNT_LAST) state_nx = SAMPLE;
      end
      SAMPLE: begin
        fail_nx = fail_cur;
        if (idx == 2'd3) begin
          pass_nx  = (fail_cur == 4'd0);
          state_nx = DONE;
        end else begin
          idx_nx   = idx_inc;
          cnt_nx   = 8'd0;
          a_nx     = idx_inc[1];
          b_nx     = idx_inc[0];
          state_nx = SETTLE;
        end
      end
      DONE: begin
        done_c   = 1'b1;
        busy_nx  = 1'b0;
        a_nx     = 1'b0;
        b_nx     = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.a_out    = a_r;
  assign bus.b_out    = b_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_c;
  assign bus.pass     = pass_r;
  assign bus.fail_vec = fail_r;

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: default AND build plus an XOR build with
// a shorter settle time, with ideal and faulty gate models on y_in.
module tb_gate_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_drv;
  logic sel;
  int   mode;
  int   checks;
  int   passed;

  gate_exerciser_if ifc0 ();
  gate_exerciser_if ifc1 ();

  gate_exerciser dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc0.slave)
  );

  gate_exerciser #(
    .SETTLE_CYCLES (3),
    .TRUTH         (4'b0110)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc1.slave)
  );

  // 0: AND, 1: stuck at 0, 2: OR, 3: XOR
  function automatic logic gate_fn(input int m, input logic a, input logic b);
    case (m)
      0:       return a & b;
      1:       return 1'b0;
      2:       return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign ifc0.y_in  = gate_fn(mode, ifc0.a_out, ifc0.b_out);
  assign ifc1.y_in  = gate_fn(mode, ifc1.a_out, ifc1.b_out);
  assign ifc0.start = start_drv & ~sel;
  assign ifc1.start = start_drv & sel;

  logic       o_busy, o_done, o_pass;
  logic [1:0] o_ab;
  logic [3:0] o_fail;
  assign o_busy = sel ? ifc1.busy : ifc0.busy;
  assign o_done = sel ? ifc1.done : ifc0.done;
  assign o_pass = sel ? ifc1.pass : ifc0.pass;
  assign o_ab   = sel ? {ifc1.a_out, ifc1.b_out} : {ifc0.a_out, ifc0.b_out};
  assign o_fail = sel ? ifc1.fail_vec : ifc0.fail_vec;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run (E0 at the first edge) and checks every cycle through E(last+1).
  task automatic run_vectors(input string name, input int s, input logic exp_pass,
                             input logic [3:0] exp_fail, input int restart_edge,
                             input bit hold_end);
    int         last;
    logic [1:0] exp_ab;
    last = 4 * (s + 1);
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    checks++;
    if ({o_busy, o_done, o_ab, o_pass, o_fail} !== {1'b1, 1'b0, 2'b00, 1'b0, 4'b0000})
      $display("FAIL %s_e0: got busy=%b done=%b ab=%b pass=%b fail=%b, want 1 0 00 0 0000",
               name, o_busy, o_done, o_ab, o_pass, o_fail);
    else passed++;
    for (int n = 1; n <= last + 1; n++) begin
      if (n == restart_edge) start_drv = 1'b1;
      if (hold_end && n == last + 1) start_drv = 1'b1;
      tick();
      if (n == restart_edge) start_drv = 1'b0;
      if (n > last)       exp_ab = 2'b00;
      else if (n == last) exp_ab = 2'b11;
      else                exp_ab = 2'(n / (s + 1));
      checks++;
      if (o_done !== (n == last))
        $display("FAIL %s_done_e%0d: got %b want %b", name, n, o_done, (n == last));
      else passed++;
      checks++;
      if (o_busy !== (n <= last))
        $display("FAIL %s_busy_e%0d: got %b want %b", name, n, o_busy, (n <= last));
      else passed++;
      checks++;
      if (o_ab !== exp_ab)
        $display("FAIL %s_ab_e%0d: got %b want %b", name, n, o_ab, exp_ab);
      else passed++;
      if (n >= last) begin
        checks++;
        if ({o_pass, o_fail} !== {exp_pass, exp_fail})
          $display("FAIL %s_result_e%0d: got pass=%b fail=%b want pass=%b fail=%b",
                   name, n, o_pass, o_fail, exp_pass, exp_fail);
        else passed++;
      end
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    mode = 0;
    start_drv = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ifc0.busy, ifc0.done, ifc0.a_out, ifc0.b_out, ifc0.pass, ifc0.fail_vec} !== 9'd0)
      $display("FAIL reset_dut0: got %b want 000000000",
               {ifc0.busy, ifc0.done, ifc0.a_out, ifc0.b_out, ifc0.pass, ifc0.fail_vec});
    else passed++;
    checks++;
    if ({ifc1.busy, ifc1.done, ifc1.a_out, ifc1.b_out, ifc1.pass, ifc1.fail_vec} !== 9'd0)
      $display("FAIL reset_dut1: got %b want 000000000",
               {ifc1.busy, ifc1.done, ifc1.a_out, ifc1.b_out, ifc1.pass, ifc1.fail_vec});
    else passed++;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_and();
    sel = 1'b0;
    mode = 0;
    run_vectors("and", 4, 1'b1, 4'b0000, -1, 1'b0);
    tick();
  endtask

  task automatic test_stuck_zero();
    sel = 1'b0;
    mode = 1;
    run_vectors("zero", 4, 1'b0, 4'b1000, -1, 1'b0);
    tick();
  endtask

  task automatic test_or();
    sel = 1'b0;
    mode = 2;
    run_vectors("or", 4, 1'b0, 4'b0110, -1, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    bit seen_done;
    sel = 1'b0;
    mode = 2;
    run_vectors("restart", 4, 1'b0, 4'b0110, 7, 1'b1);
    // start still high: next edge is E0 of the second run
    tick();
    start_drv = 1'b0;
    checks++;
    if ({o_busy, o_pass, o_fail} !== {1'b1, 1'b0, 4'b0000})
      $display("FAIL b2b_e0: got busy=%b pass=%b fail=%b want 1 0 0000",
               o_busy, o_pass, o_fail);
    else passed++;
    seen_done = 1'b0;
    for (int n = 1; n <= 21; n++) begin
      tick();
      if (n == 20) begin
        checks++;
        if (o_done !== 1'b1) $display("FAIL b2b_done_e20: got %b want 1", o_done);
        else passed++;
      end else if (o_done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) $display("FAIL b2b_stray_done: got %b want 0", seen_done);
    else passed++;
    checks++;
    if ({o_busy, o_pass, o_fail} !== {1'b0, 1'b0, 4'b0110})
      $display("FAIL b2b_result: got busy=%b pass=%b fail=%b want 0 0 0110",
               o_busy, o_pass, o_fail);
    else passed++;
  endtask

  task automatic test_abort();
    bit seen_done;
    bit seen_busy;
    sel = 1'b0;
    mode = 0;
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({o_busy, o_done, o_ab, o_pass, o_fail} !== 9'd0)
      $display("FAIL abort_outputs: got %b want 000000000",
               {o_busy, o_done, o_ab, o_pass, o_fail});
    else passed++;
    rst_n = 1'b1;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (o_done === 1'b1) seen_done = 1'b1;
      if (o_busy === 1'b1) seen_busy = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) $display("FAIL abort_no_done: got %b want 0", seen_done);
    else passed++;
    checks++;
    if (seen_busy !== 1'b0) $display("FAIL abort_idle: got %b want 0", seen_busy);
    else passed++;
  endtask

  task automatic test_xor_short_settle();
    sel = 1'b1;
    mode = 3;
    run_vectors("xor", 3, 1'b1, 4'b0000, -1, 1'b0);
    tick();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    start_drv = 1'b0;
    sel = 1'b0;
    mode = 0;
    test_reset();
    test_and();
    test_stuck_zero();
    test_or();
    test_back_to_back();
    test_abort();
    test_xor_short_settle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gate_exerciser.md
# gate_exerciser

Self-checking stimulus generator for the two-input logic-gate blocks on the Mojo board. It drives the gate's A/B inputs through all four input combinations and waits a settle time after each one. It then samples the gate's Y output and compares it against an expected truth table. It reports a pass flag and a per-vector failure map that the top level routes to LEDs, giving a standalone bring-up check of any gate block without external equipment.

## Interface
- SETTLE_CYCLES, 4: cycles each vector is held before Y is sampled; legal range 3..255.
- TRUTH, 4'b1000: expected Y per vector index {a,b}; bit i is the expected Y for idx=i. The default is AND.

- clk  in  1  system clock (50 MHz on Mojo).
- rst_n  in  1  reset; synchronous and active-low.
- start  in  1  level; sampled on clk; begins a run when idle.
- y_in  in  1  output of the gate under test; asynchronous to clk, combinational path.
- a_out  out  1  gate A input; registered.
- b_out  out  1  gate B input; registered.
- busy  out  1  high while a run is in progress.
- done  out  1  single-cycle pulse at the end of a run.
- pass  out  1  high when the last completed run had zero mismatches; held until the next start.
- fail_vec  out  4  bit i set when vector idx=i mismatched; held until the next start.

## Operation
- Y synchronizer: y_in passes through two flops, producing y_sync. Only y_sync is compared.
- Vector index idx is 2 bits. a_out=idx[1] and b_out=idx[0] while busy; both are 0 otherwise.
- Settle counter cnt is 8 bits.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - busy=0, a_out=b_out=0.
  - On a clk edge with start=1: idx<=0, cnt<=0, fail_vec<=0, pass<=0, busy<=1, then go to SETTLE.
- SETTLE:
  - cnt increments every cycle.
  - At the edge where cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - fail_vec[idx] <= (y_sync != TRUTH[idx]).
  - If idx==3, go to DONE. Set pass <= 1 only if every fail_vec bit, including the current comparison, is 0.
  - Otherwise: idx<=idx+1, cnt<=0, return to SETTLE.
- DONE:
  - done=1 for exactly this one cycle, busy<=0, a_out/b_out<=0, then go to IDLE.
- start is ignored in SETTLE, SAMPLE and DONE.
- A start held high continuously produces back-to-back runs, with one IDLE cycle between done and the next busy.
- Reset values (the state after any clk edge with rst_n=0): state=IDLE, a_out=0, b_out=0, busy=0, done=0, pass=0, fail_vec=0, idx=0, cnt=0, synchronizer flops=0.
- Reset during a run aborts it immediately. No done pulse is produced, and results are cleared.

## Timing
- Let E0 be the clk edge at which start=1 is sampled in IDLE. busy, a_out and b_out take their new values after E0.
- Vector k (k=0..3):
  - a/b are driven from edge E(k·(S+1)).
  - Y is compared at edge E((k+1)·(S+1)), where S=SETTLE_CYCLES.
- y_sync at the compare edge reflects y_in two edges earlier. This falls inside the settle window because S≥3.
- done is high for the cycle following edge E(4·(S+1)); with the default S=4 this is edge E20.
- busy falls after edge E(4·(S+1)+1). pass and fail_vec are valid from the done cycle onward.
- Total run length is 4·(S+1)+1 cycles, start to IDLE.

## Test plan
- Default parameters, y_in driven by an ideal AND of a_out/b_out, start pulsed for 1 cycle:
  - done is high only in the cycle after E20.
  - pass=1, fail_vec=4'b0000.
  - a/b sequence is 00,01,10,11, each held 5 cycles.
- y_in tied to 0, default parameters: pass=0, fail_vec=4'b1000, done after E20.
- y_in driven by OR of a_out/b_out: pass=0, fail_vec=4'b0110.
- start re-asserted at E7 during a run:
  - No restart; done still occurs after E20.
  - After done, start held high: second run's E0 falls one cycle after the done cycle, and fail_vec clears at that edge.
- rst_n=0 at E10 of a run:
  - All outputs read 0 after E10.
  - No done pulse; the block stays in IDLE until the next start.
- TRUTH=4'b0110, SETTLE_CYCLES=3, y_in driven by XOR: pass=1, fail_vec=0, done in the cycle after E16.
